// File: rtl/logic_axi4_lite_pkg.sv
// logic_axi4_lite_pkg: shared AXI4-Lite channel types.
// access_t carries AxPROT, response_t carries BRESP/RRESP.
package logic_axi4_lite_pkg;

  typedef struct packed {
    logic instr;
    logic nonsecure;
    logic privileged;
  } access_t;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } response_t;

endpackage

// File: rtl/logic_axi4_lite_queue_pkg.sv
// logic_axi4_lite_queue_pkg: outstanding-counter width helper
// and parameter legality check for logic_axi4_lite_queue.
package logic_axi4_lite_queue_pkg;

  function automatic int count_width(input int max_val);
    return $clog2(max_val + 1);
  endfunction

  function automatic bit params_legal(
    input int data_bytes,
    input int addr_w,
    input int aw_d,
    input int w_d,
    input int b_d,
    input int ar_d,
    input int r_d,
    input int max_w,
    input int max_r
  );
    return (data_bytes >= 1) && (addr_w >= 1) &&
           (aw_d >= 1) && (w_d >= 1) && (b_d >= 1) &&
           (ar_d >= 1) && (r_d >= 1) &&
           (max_w >= 1) && (max_r >= 1);
  endfunction

endpackage

// File: rtl/logic_axi4_lite_queue_fifo.sv
// logic_axi4_lite_queue_fifo: registered valid/ready sync FIFO.
// Ports: clk, rst_n (sync, low), in_*, out_*; level (STATUS_EN).
// Optional: LOGIC_AXI4_LITE_QUEUE_STATUS_EN adds the level output.
module logic_axi4_lite_queue_fifo #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef LOGIC_AXI4_LITE_QUEUE_STATUS_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0] level
`endif
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [LW-1:0]    count;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;

  // Explicit compare-and-clear so non-power-of-2 depths wrap.
  function automatic logic [PW-1:0] wrap_inc(
    input logic [PW-1:0] p
  );
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full      = (count == LW'(DEPTH));
  assign empty     = (count == '0);
  // Gated by reset so handshakes stay low while held in reset.
  assign in_ready  = rst_n & ~full;
  assign out_valid = rst_n & ~empty;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign out_data  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wrap_inc(wr_ptr);
      if (pop)  rd_ptr <= wrap_inc(rd_ptr);
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

`ifdef LOGIC_AXI4_LITE_QUEUE_STATUS_EN
  assign level = rst_n ? count : '0;
`endif

endmodule

// File: rtl/logic_axi4_lite_queue.sv
// logic_axi4_lite_queue: AXI4-Lite queue, one FIFO per channel,
// AW/AR acceptance limited by outstanding write/read counters.
// Ports: aclk, areset_n (sync, low), slave_* upstream side,
// master_* downstream side. LOGIC_AXI4_LITE_QUEUE_STATUS_EN adds
// write_/read_outstanding and per-FIFO *_level outputs.
module logic_axi4_lite_queue
  import logic_axi4_lite_pkg::*;
  import logic_axi4_lite_queue_pkg::*;
#(
  parameter int DATA_BYTES    = 4,
  parameter int ADDRESS_WIDTH = 1,
  parameter int AW_DEPTH      = 2,
  parameter int W_DEPTH       = 2,
  parameter int B_DEPTH       = 2,
  parameter int AR_DEPTH      = 2,
  parameter int R_DEPTH       = 2,
  parameter int MAX_WRITES    = 4,
  parameter int MAX_READS     = 4
) (
  input  logic                     aclk,
  input  logic                     areset_n,
  input  logic                     slave_awvalid,
  output logic                     slave_awready,
  input  logic [ADDRESS_WIDTH-1:0] slave_awaddr,
  input  logic [2:0]               slave_awprot,
  input  logic                     slave_wvalid,
  output logic                     slave_wready,
  input  logic [8*DATA_BYTES-1:0]  slave_wdata,
  input  logic [DATA_BYTES-1:0]    slave_wstrb,
  output logic                     slave_bvalid,
  input  logic                     slave_bready,
  output logic [1:0]               slave_bresp,
  input  logic                     slave_arvalid,
  output logic                     slave_arready,
  input  logic [ADDRESS_WIDTH-1:0] slave_araddr,
  input  logic [2:0]               slave_arprot,
  output logic                     slave_rvalid,
  input  logic                     slave_rready,
  output logic [8*DATA_BYTES-1:0]  slave_rdata,
  output logic [1:0]               slave_rresp,
  output logic                     master_awvalid,
  input  logic                     master_awready,
  output logic [ADDRESS_WIDTH-1:0] master_awaddr,
  output logic [2:0]               master_awprot,
  output logic                     master_wvalid,
  input  logic                     master_wready,
  output logic [8*DATA_BYTES-1:0]  master_wdata,
  output logic [DATA_BYTES-1:0]    master_wstrb,
  input  logic                     master_bvalid,
  output logic                     master_bready,
  input  logic [1:0]               master_bresp,
  output logic                     master_arvalid,
  input  logic                     master_arready,
  output logic [ADDRESS_WIDTH-1:0] master_araddr,
  output logic [2:0]               master_arprot,
  input  logic                     master_rvalid,
  output logic                     master_rready,
  input  logic [8*DATA_BYTES-1:0]  master_rdata,
  input  logic [1:0]               master_rresp
`ifdef LOGIC_AXI4_LITE_QUEUE_STATUS_EN
  ,
  output logic [$clog2(MAX_WRITES+1)-1:0] write_outstanding,
  output logic [$clog2(MAX_READS+1)-1:0]  read_outstanding,
  output logic [$clog2(AW_DEPTH+1)-1:0]   aw_level,
  output logic [$clog2(W_DEPTH+1)-1:0]    w_level,
  output logic [$clog2(B_DEPTH+1)-1:0]    b_level,
  output logic [$clog2(AR_DEPTH+1)-1:0]   ar_level,
  output logic [$clog2(R_DEPTH+1)-1:0]    r_level
`endif
);

  localparam int DW  = 8 * DATA_BYTES;
  localparam int AXW = ADDRESS_WIDTH + 3;
  localparam int WW  = DW + DATA_BYTES;
  localparam int RW  = DW + 2;
  localparam int WCW = count_width(MAX_WRITES);
  localparam int RCW = count_width(MAX_READS);

  if (!params_legal(DATA_BYTES, ADDRESS_WIDTH, AW_DEPTH, W_DEPTH,
                    B_DEPTH, AR_DEPTH, R_DEPTH, MAX_WRITES,
                    MAX_READS)) begin : g_bad_params
    $error("logic_axi4_lite_queue: illegal parameters");
  end

  logic [AXW-1:0] aw_q;
  logic [WW-1:0]  w_q;
  logic [RW-1:0]  r_q;
  logic [AXW-1:0] ar_q;
  access_t        aw_prot;
  access_t        ar_prot;
  response_t      b_resp;
  response_t      r_resp;
  logic [1:0]     b_q;

  logic           aw_in_ready;
  logic           ar_in_ready;
  logic [WCW-1:0] wr_count;
  logic [RCW-1:0] rd_count;
  logic           wr_room;
  logic           rd_room;
  logic           aw_push;
  logic           b_pop;
  logic           ar_push;
  logic           r_pop;

  assign wr_room       = (wr_count != WCW'(MAX_WRITES));
  assign rd_room       = (rd_count != RCW'(MAX_READS));
  assign slave_awready = aw_in_ready & wr_room;
  assign slave_arready = ar_in_ready & rd_room;
  assign aw_push       = slave_awvalid & slave_awready;
  assign ar_push       = slave_arvalid & slave_arready;
  assign b_pop         = slave_bvalid & slave_bready;
  assign r_pop         = slave_rvalid & slave_rready;

  logic_axi4_lite_queue_fifo #(.WIDTH(AXW), .DEPTH(AW_DEPTH)) u_aw (
    .clk       (aclk),
    .rst_n     (areset_n),
    .in_valid  (slave_awvalid & wr_room),
    .in_ready  (aw_in_ready),
    .in_data   ({slave_awaddr, slave_awprot}),
    .out_valid (master_awvalid),
    .out_ready (master_awready),
    .out_data  (aw_q)
`ifdef LOGIC_AXI4_LITE_QUEUE_STATUS_EN
    ,
    .level     (aw_level)
`endif
  );

  logic_axi4_lite_queue_fifo #(.WIDTH(WW), .DEPTH(W_DEPTH)) u_w (
    .clk       (aclk),
    .rst_n     (areset_n),
    .in_valid  (slave_wvalid),
    .in_ready  (slave_wready),
    .in_data   ({slave_wdata, slave_wstrb}),
    .out_valid (master_wvalid),
    .out_ready (master_wready),
    .out_data  (w_q)
`ifdef LOGIC_AXI4_LITE_QUEUE_STATUS_EN
    ,
    .level     (w_level)
`endif
  );

  logic_axi4_lite_queue_fifo #(.WIDTH(2), .DEPTH(B_DEPTH)) u_b (
    .clk       (aclk),
    .rst_n     (areset_n),
    .in_valid  (master_bvalid),
    .in_ready  (master_bready),
    .in_data   (master_bresp),
    .out_valid (slave_bvalid),
    .out_ready (slave_bready),
    .out_data  (b_q)
`ifdef LOGIC_AXI4_LITE_QUEUE_STATUS_EN
    ,
    .level     (b_level)
`endif
  );

  logic_axi4_lite_queue_fifo #(.WIDTH(AXW), .DEPTH(AR_DEPTH)) u_ar (
    .clk       (aclk),
    .rst_n     (areset_n),
    .in_valid  (slave_arvalid & rd_room),
    .in_ready  (ar_in_ready),
    .in_data   ({slave_araddr, slave_arprot}),
    .out_valid (master_arvalid),
    .out_ready (master_arready),
    .out_data  (ar_q)
`ifdef LOGIC_AXI4_LITE_QUEUE_STATUS_EN
    ,
    .level     (ar_level)
`endif
  );

  logic_axi4_lite_queue_fifo #(.WIDTH(RW), .DEPTH(R_DEPTH)) u_r (
    .clk       (aclk),
    .rst_n     (areset_n),
    .in_valid  (master_rvalid),
    .in_ready  (master_rready),
    .in_data   ({master_rdata, master_rresp}),
    .out_valid (slave_rvalid),
    .out_ready (slave_rready),
    .out_data  (r_q)
`ifdef LOGIC_AXI4_LITE_QUEUE_STATUS_EN
    ,
    .level     (r_level)
`endif
  );

  assign {master_awaddr, aw_prot}    = aw_q;
  assign {master_wdata, master_wstrb} = w_q;
  assign {master_araddr, ar_prot}    = ar_q;
  assign b_resp        = response_t'(b_q);
  assign r_resp        = response_t'(r_q[1:0]);
  assign slave_rdata   = r_q[RW-1:2];
  assign master_awprot = aw_prot;
  assign master_arprot = ar_prot;
  assign slave_bresp   = b_resp;
  assign slave_rresp   = r_resp;

  // Simultaneous accept and retire leaves the count unchanged.
  always_ff @(posedge aclk) begin
    if (!areset_n) begin
      wr_count <= '0;
    end else if (aw_push && !b_pop) begin
      wr_count <= wr_count + 1'b1;
    end else if (b_pop && !aw_push && wr_count != '0) begin
      wr_count <= wr_count - 1'b1;
    end
  end

  always_ff @(posedge aclk) begin
    if (!areset_n) begin
      rd_count <= '0;
    end else if (ar_push && !r_pop) begin
      rd_count <= rd_count + 1'b1;
    end else if (r_pop && !ar_push && rd_count != '0) begin
      rd_count <= rd_count - 1'b1;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset_n && b_pop)
      assert (wr_count != '0)
        else $error("B handshake with no outstanding write");
    if (areset_n && r_pop)
      assert (rd_count != '0)
        else $error("R handshake with no outstanding read");
  end

`ifdef LOGIC_AXI4_LITE_QUEUE_STATUS_EN
  assign write_outstanding = areset_n ? wr_count : '0;
  assign read_outstanding  = areset_n ? rd_count : '0;
`endif

endmodule

// File: tb/tb_logic_axi4_lite_queue.sv
// tb_logic_axi4_lite_queue: directed scoreboard bench for
// logic_axi4_lite_queue (ADDRESS_WIDTH=8, AR_DEPTH=3).
module tb_logic_axi4_lite_queue;

  logic        aclk;
  logic        areset_n;
  logic        slave_awvalid, slave_awready;
  logic [7:0]  slave_awaddr;
  logic [2:0]  slave_awprot;
  logic        slave_wvalid, slave_wready;
  logic [31:0] slave_wdata;
  logic [3:0]  slave_wstrb;
  logic        slave_bvalid, slave_bready;
  logic [1:0]  slave_bresp;
  logic        slave_arvalid, slave_arready;
  logic [7:0]  slave_araddr;
  logic [2:0]  slave_arprot;
  logic        slave_rvalid, slave_rready;
  logic [31:0] slave_rdata;
  logic [1:0]  slave_rresp;
  logic        master_awvalid, master_awready;
  logic [7:0]  master_awaddr;
  logic [2:0]  master_awprot;
  logic        master_wvalid, master_wready;
  logic [31:0] master_wdata;
  logic [3:0]  master_wstrb;
  logic        master_bvalid, master_bready;
  logic [1:0]  master_bresp;
  logic        master_arvalid, master_arready;
  logic [7:0]  master_araddr;
  logic [2:0]  master_arprot;
  logic        master_rvalid, master_rready;
  logic [31:0] master_rdata;
  logic [1:0]  master_rresp;
`ifdef LOGIC_AXI4_LITE_QUEUE_STATUS_EN
  logic [2:0]  write_outstanding, read_outstanding;
  logic [1:0]  aw_level, w_level, b_level, ar_level, r_level;
`endif

  logic_axi4_lite_queue #(
    .ADDRESS_WIDTH (8),
    .AR_DEPTH      (3)
  ) dut (
    .aclk           (aclk),
    .areset_n       (areset_n),
    .slave_awvalid  (slave_awvalid),
    .slave_awready  (slave_awready),
    .slave_awaddr   (slave_awaddr),
    .slave_awprot   (slave_awprot),
    .slave_wvalid   (slave_wvalid),
    .slave_wready   (slave_wready),
    .slave_wdata    (slave_wdata),
    .slave_wstrb    (slave_wstrb),
    .slave_bvalid   (slave_bvalid),
    .slave_bready   (slave_bready),
    .slave_bresp    (slave_bresp),
    .slave_arvalid  (slave_arvalid),
    .slave_arready  (slave_arready),
    .slave_araddr   (slave_araddr),
    .slave_arprot   (slave_arprot),
    .slave_rvalid   (slave_rvalid),
    .slave_rready   (slave_rready),
    .slave_rdata    (slave_rdata),
    .slave_rresp    (slave_rresp),
    .master_awvalid (master_awvalid),
    .master_awready (master_awready),
    .master_awaddr  (master_awaddr),
    .master_awprot  (master_awprot),
    .master_wvalid  (master_wvalid),
    .master_wready  (master_wready),
    .master_wdata   (master_wdata),
    .master_wstrb   (master_wstrb),
    .master_bvalid  (master_bvalid),
    .master_bready  (master_bready),
    .master_bresp   (master_bresp),
    .master_arvalid (master_arvalid),
    .master_arready (master_arready),
    .master_araddr  (master_araddr),
    .master_arprot  (master_arprot),
    .master_rvalid  (master_rvalid),
    .master_rready  (master_rready),
    .master_rdata   (master_rdata),
`ifdef LOGIC_AXI4_LITE_QUEUE_STATUS_EN
    .write_outstanding (write_outstanding),
    .read_outstanding  (read_outstanding),
    .aw_level          (aw_level),
    .w_level           (w_level),
    .b_level           (b_level),
    .ar_level          (ar_level),
    .r_level           (r_level),
`endif
    .master_rresp   (master_rresp)
  );

  typedef struct {
    logic [31:0] v;
    int          cyc;
  } ent_t;

  ent_t exp_aw[$];
  ent_t exp_w[$];
  ent_t exp_b[$];
  ent_t exp_ar[$];
  ent_t exp_r[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int maw_seen = 0;
  bit chk_lat = 0;

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc <= cyc + 1;

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // Monitors: each output handshake pops the next expected beat.
  always @(negedge aclk) begin
    ent_t e;
    if (master_awvalid && master_awready) begin
      maw_seen++;
      check("aw_pending", 64'(exp_aw.size() != 0), 1);
      if (exp_aw.size() != 0) begin
        e = exp_aw.pop_front();
        check("m_awaddr", master_awaddr, e.v);
        if (chk_lat) check("aw_latency", cyc, e.cyc);
      end
    end
    if (master_wvalid && master_wready) begin
      check("w_pending", 64'(exp_w.size() != 0), 1);
      if (exp_w.size() != 0) begin
        e = exp_w.pop_front();
        check("m_wdata", master_wdata, e.v);
        if (chk_lat) check("w_latency", cyc, e.cyc);
      end
    end
    if (master_arvalid && master_arready) begin
      check("ar_pending", 64'(exp_ar.size() != 0), 1);
      if (exp_ar.size() != 0) begin
        e = exp_ar.pop_front();
        check("m_araddr", master_araddr, e.v);
      end
    end
    if (slave_bvalid && slave_bready) begin
      check("b_pending", 64'(exp_b.size() != 0), 1);
      if (exp_b.size() != 0) begin
        e = exp_b.pop_front();
        check("s_bresp", slave_bresp, e.v);
      end
    end
    if (slave_rvalid && slave_rready) begin
      check("r_pending", 64'(exp_r.size() != 0), 1);
      if (exp_r.size() != 0) begin
        e = exp_r.pop_front();
        check("s_rdata", slave_rdata, e.v);
        check("s_rresp", slave_rresp, 2'b00);
      end
    end
  end

  task automatic ar_push(input logic [7:0] a, input int bound,
                         output bit ok);
    slave_arvalid = 1'b1;
    slave_araddr  = a;
    ok = 1'b0;
    for (int n = 0; n < bound && !ok; n++) begin
      @(negedge aclk);
      if (slave_arready) begin
        exp_ar.push_back('{v: 32'(a), cyc: cyc + 1});
        ok = 1'b1;
      end
      tick();
    end
    if (ok) slave_arvalid = 1'b0;
  endtask

  task automatic aw_push(input logic [7:0] a, input int bound,
                         output bit ok);
    slave_awvalid = 1'b1;
    slave_awaddr  = a;
    ok = 1'b0;
    for (int n = 0; n < bound && !ok; n++) begin
      @(negedge aclk);
      if (slave_awready) begin
        exp_aw.push_back('{v: 32'(a), cyc: cyc + 1});
        ok = 1'b1;
      end
      tick();
    end
    if (ok) slave_awvalid = 1'b0;
  endtask

  task automatic r_beat(input logic [31:0] d);
    master_rvalid = 1'b1;
    master_rdata  = d;
    master_rresp  = 2'b00;
    @(negedge aclk);
    check("m_rready", master_rready, 1);
    if (master_rready) exp_r.push_back('{v: d, cyc: 0});
    tick();
    master_rvalid = 1'b0;
  endtask

  int  aw_sent, w_sent, b_given;
  bit  lim_seen, ok;

  initial begin
    areset_n = 0;
    slave_awvalid = 0; slave_awaddr = 0; slave_awprot = 0;
    slave_wvalid = 0; slave_wdata = 0; slave_wstrb = 0;
    slave_bready = 0;
    slave_arvalid = 0; slave_araddr = 0; slave_arprot = 0;
    slave_rready = 0;
    master_awready = 0; master_wready = 0;
    master_bvalid = 0; master_bresp = 0;
    master_arready = 0;
    master_rvalid = 0; master_rdata = 0; master_rresp = 0;

    // Reset and idle
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    check("rst_s_awready", slave_awready, 0);
    check("rst_s_wready", slave_wready, 0);
    check("rst_s_arready", slave_arready, 0);
    check("rst_m_bready", master_bready, 0);
    check("rst_m_rready", master_rready, 0);
    check("rst_m_awvalid", master_awvalid, 0);
    check("rst_m_wvalid", master_wvalid, 0);
    check("rst_m_arvalid", master_arvalid, 0);
    check("rst_s_bvalid", slave_bvalid, 0);
    check("rst_s_rvalid", slave_rvalid, 0);
    tick();
    areset_n = 1;
    tick();
    @(negedge aclk);
    check("idle_s_awready", slave_awready, 1);
    check("idle_s_wready", slave_wready, 1);
    check("idle_s_arready", slave_arready, 1);
    check("idle_m_bready", master_bready, 1);
    check("idle_m_rready", master_rready, 1);
    check("idle_m_awvalid", master_awvalid, 0);
    check("idle_m_wvalid", master_wvalid, 0);
    check("idle_m_arvalid", master_arvalid, 0);
`ifdef LOGIC_AXI4_LITE_QUEUE_STATUS_EN
    check("idle_wr_out", write_outstanding, 0);
    check("idle_rd_out", read_outstanding, 0);
`endif
    tick();

    // Streaming writes with B held off to show the limiter
    master_awready = 1; master_wready = 1; slave_bready = 1;
    slave_wstrb = 4'hf;
    chk_lat = 1;
    aw_sent = 0; w_sent = 0; b_given = 0; lim_seen = 0;
    for (int c = 0; c < 60 && b_given < 8; c++) begin
      slave_awvalid = (aw_sent < 8);
      slave_awaddr  = 8'(aw_sent);
      slave_wvalid  = (w_sent < 8);
      slave_wdata   = 32'hA0 + 32'(w_sent);
      master_bvalid = (c >= 12) && (b_given < maw_seen);
      master_bresp  = 2'b00;
      @(negedge aclk);
      if (aw_sent == 4 && c < 12 && !lim_seen) begin
        check("aw_limit", slave_awready, 0);
`ifdef LOGIC_AXI4_LITE_QUEUE_STATUS_EN
        check("aw_limit_cnt", write_outstanding, 4);
`endif
        lim_seen = 1;
      end
      if (slave_awvalid && slave_awready) begin
        exp_aw.push_back('{v: 32'(aw_sent), cyc: cyc + 1});
        aw_sent++;
      end
      if (slave_wvalid && slave_wready) begin
        exp_w.push_back('{v: slave_wdata, cyc: cyc + 1});
        w_sent++;
      end
      if (master_bvalid && master_bready) begin
        exp_b.push_back('{v: 32'(2'b00), cyc: 0});
        b_given++;
      end
      tick();
    end
    slave_awvalid = 0; slave_wvalid = 0; master_bvalid = 0;
    repeat (6) tick();
    chk_lat = 0;
    check("stream_limit_seen", 64'(lim_seen), 1);
    check("stream_aw_sent", aw_sent, 8);
    check("stream_w_sent", w_sent, 8);
    check("stream_b_given", b_given, 8);
`ifdef LOGIC_AXI4_LITE_QUEUE_STATUS_EN
    check("stream_wr_out", write_outstanding, 0);
`endif

    // Read limiter: fifth AR waits for one R completion
    master_arready = 1; slave_rready = 1;
    for (int i = 0; i < 4; i++) begin
      ar_push(8'h10 + 8'(i), 4, ok);
      check("ar_accept", 64'(ok), 1);
    end
    ar_push(8'h14, 3, ok);
    check("ar_limit_stall", 64'(ok), 0);
`ifdef LOGIC_AXI4_LITE_QUEUE_STATUS_EN
    check("ar_limit_cnt", read_outstanding, 4);
`endif
    r_beat(32'hDEADBEEF);
    ar_push(8'h14, 4, ok);
    check("ar_after_r", 64'(ok), 1);
    for (int i = 0; i < 4; i++) r_beat(32'h100 + 32'(i));
    repeat (4) tick();
`ifdef LOGIC_AXI4_LITE_QUEUE_STATUS_EN
    check("rd_drained", read_outstanding, 0);
`endif

    // AR FIFO full under master backpressure
    master_arready = 0;
    for (int i = 0; i < 3; i++) begin
      ar_push(8'h20 + 8'(i), 2, ok);
      check("ar_fill", 64'(ok), 1);
    end
    slave_arvalid = 1; slave_araddr = 8'h23;
    @(negedge aclk);
    check("ar_full", slave_arready, 0);
`ifdef LOGIC_AXI4_LITE_QUEUE_STATUS_EN
    check("ar_level_full", ar_level, 3);
`endif
    tick();
    master_arready = 1;
    @(negedge aclk);
    check("ar_full_pop", slave_arready, 0);
    tick();
    @(negedge aclk);
    check("ar_ready_after_pop", slave_arready, 1);
    if (slave_arready) exp_ar.push_back('{v: 32'h23, cyc: 0});
    tick();
    slave_arvalid = 0;
    repeat (4) tick();
    for (int i = 0; i < 4; i++) r_beat(32'h200 + 32'(i));
    repeat (4) tick();

    // B and AW handshakes in the same cycle at MAX_WRITES-1
    slave_bready = 0; master_awready = 1;
    for (int i = 0; i < 3; i++) begin
      aw_push(8'h30 + 8'(i), 2, ok);
      check("sim_aw_fill", 64'(ok), 1);
    end
    master_bvalid = 1; master_bresp = 2'b00;
    @(negedge aclk);
    if (master_bready) exp_b.push_back('{v: 0, cyc: 0});
    tick();
    master_bvalid = 0;
    slave_awvalid = 1; slave_awaddr = 8'h33; slave_bready = 1;
    @(negedge aclk);
    check("sim_awready", slave_awready, 1);
    check("sim_bvalid", slave_bvalid, 1);
    if (slave_awready) exp_aw.push_back('{v: 32'h33, cyc: 0});
    tick();
    slave_awvalid = 0;
    @(negedge aclk);
    check("sim_awready_kept", slave_awready, 1);
`ifdef LOGIC_AXI4_LITE_QUEUE_STATUS_EN
    check("sim_wr_out", write_outstanding, 3);
`endif
    tick();
    b_given = 0;
    for (int i = 0; i < 8 && b_given < 3; i++) begin
      master_bvalid = 1;
      @(negedge aclk);
      if (master_bready) begin
        exp_b.push_back('{v: 0, cyc: 0});
        b_given++;
      end
      tick();
    end
    master_bvalid = 0;
    repeat (4) tick();
    check("sim_b_drain", b_given, 3);

    // Reset with queued W beats and an outstanding write
    master_wready = 0; master_awready = 0;
    slave_wvalid = 1; slave_wdata = 32'h55;
    @(negedge aclk);
    check("rw_w0_ready", slave_wready, 1);
    tick();
    slave_wdata = 32'h66;
    @(negedge aclk);
    check("rw_w1_ready", slave_wready, 1);
    tick();
    slave_wvalid = 0;
    slave_awvalid = 1; slave_awaddr = 8'h40;
    @(negedge aclk);
    check("rw_aw_ready", slave_awready, 1);
    tick();
    slave_awvalid = 0;
    @(negedge aclk);
    check("rw_w_queued", master_wvalid, 1);
    tick();
    areset_n = 0;
    repeat (2) tick();
    @(negedge aclk);
    check("rw_in_rst_wvalid", master_wvalid, 0);
    check("rw_in_rst_wready", slave_wready, 0);
    tick();
    areset_n = 1;
    master_wready = 1; master_awready = 1;
    @(negedge aclk);
    check("rw_post_wvalid", master_wvalid, 0);
    check("rw_post_awvalid", master_awvalid, 0);
    check("rw_post_wready", slave_wready, 1);
`ifdef LOGIC_AXI4_LITE_QUEUE_STATUS_EN
    check("rw_post_wr_out", write_outstanding, 0);
    check("rw_post_rd_out", read_outstanding, 0);
    check("rw_post_w_level", w_level, 0);
`endif
    repeat (3) tick();

    check("sb_aw_empty", exp_aw.size(), 0);
    check("sb_w_empty", exp_w.size(), 0);
    check("sb_b_empty", exp_b.size(), 0);
    check("sb_ar_empty", exp_ar.size(), 0);
    check("sb_r_empty", exp_r.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
